// File: rtl/capture_shift_1_if.sv
// -----------------------------------------------------------------------------
// capture_shift_1_if
//   Handshake and data bundle between a readback/debug controller and the
//   capture_shift_1 serialiser. Clock (C) and reset (CLR) are not carried here.
//
//   Signals
//     CE    : clock enable for every synchronous update
//     CAP   : capture request
//     D     : parallel word to capture (WIDTH bits)
//     RDY   : consumer ready for the current serial bit
//     Q     : current serial bit
//     VALID : Q carries a bit of an active frame
//     LAST  : Q carries the final bit of the frame
//     BUSY  : a frame is in progress (same as VALID)
//     OVR   : sticky flag, a capture request was dropped
//
//   Modports
//     master : controller side, drives CE/CAP/D/RDY
//     slave  : serialiser side, drives Q/VALID/LAST/BUSY/OVR
// -----------------------------------------------------------------------------
interface capture_shift_1_if #(
    parameter int WIDTH = 16
);
    logic             CE;
    logic             CAP;
    logic [WIDTH-1:0] D;
    logic             RDY;
    logic             Q;
    logic             VALID;
    logic             LAST;
    logic             BUSY;
    logic             OVR;

    modport master (
        output CE, CAP, D, RDY,
        input  Q, VALID, LAST, BUSY, OVR
    );

    modport slave (
        input  CE, CAP, D, RDY,
        output Q, VALID, LAST, BUSY, OVR
    );
endinterface

// File: rtl/capture_shift_1.sv
// -----------------------------------------------------------------------------
// capture_shift_1
//   Falling-edge capture and serial readback register. On a capture request
//   the parallel word D is snapshotted into a shadow register and streamed
//   out MSB-first, one bit per accepted handshake (VALID & RDY).
//
//   Parameters
//     WIDTH : captured word width, 2..64
//     INIT  : level driven on Q while no frame is active
//
//   Ports
//     C     : clock, all state changes on the falling edge
//     CLR   : asynchronous active-high clear, dominant over everything
//     bus   : capture_shift_1_if.slave (CE, CAP, D, RDY in;
//             Q, VALID, LAST, BUSY, OVR out)
//
//   Build option
//     CAPTURE_PARITY_EN : append one even-parity trailer bit (XOR of the
//                         captured word) after the data bits; LAST then
//                         marks the parity bit instead of data bit 0.
// -----------------------------------------------------------------------------
module capture_shift_1 #(
    parameter int   WIDTH = 16,
    parameter logic INIT  = 1'b0
) (
    input  logic             C,
    input  logic             CLR,
    capture_shift_1_if.slave bus
);

`ifdef CAPTURE_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shadow;
    logic [CNT_W-1:0] r_count;
    logic             r_ovr;
`ifdef CAPTURE_PARITY_EN
    logic             r_parity;
`endif

    logic w_at_last;
    logic w_accept;
    logic w_final;
    logic w_start;
    logic w_drop;
    logic w_q;
    logic w_valid;
    logic w_last;

    // Handshake decode. A capture is honoured only from IDLE or on the very
    // edge that retires the final bit, which gives gap-free back-to-back frames.
    assign w_at_last = (r_state == S_SHIFT) && (r_count == CNT_W'(FRAME - 1));
    assign w_accept  = bus.CE && (r_state == S_SHIFT) && bus.RDY;
    assign w_final   = w_accept && w_at_last;
    assign w_start   = bus.CE && bus.CAP && ((r_state == S_IDLE) || w_final);
    assign w_drop    = bus.CE && bus.CAP && (r_state == S_SHIFT) && !w_final;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(negedge C or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: default assignment first so no path leaves the target unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.CE && bus.CAP) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Staying in SHIFT when a new capture lands on the final edge.
                if (w_final && !bus.CAP) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (decoded from registers only, no input-to-output path)
    // -------------------------------------------------------------------------
    always_comb begin
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_q     = INIT;
        if (r_state == S_SHIFT) begin
            w_valid = 1'b1;
            w_last  = w_at_last;
            w_q     = r_shadow[WIDTH-1];
`ifdef CAPTURE_PARITY_EN
            // All data bits have gone; the trailer slot carries the parity.
            if (r_count == CNT_W'(WIDTH)) begin
                w_q = r_parity;
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: shadow word, bit counter, parity, overrun flag
    // -------------------------------------------------------------------------
    always_ff @(negedge C or posedge CLR) begin
        if (CLR) begin
            r_shadow <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
`ifdef CAPTURE_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (bus.CE) begin
            if (w_start) begin
                r_shadow <= bus.D;
                r_count  <= '0;
`ifdef CAPTURE_PARITY_EN
                r_parity <= ^bus.D;
`endif
            end else if (w_accept) begin
                r_shadow <= {r_shadow[WIDTH-2:0], 1'b0};
                r_count  <= r_count + 1'b1;
            end
            // Sticky until CLR; a dropped request never disturbs the frame.
            if (w_drop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign bus.Q     = w_q;
    assign bus.VALID = w_valid;
    assign bus.LAST  = w_last;
    assign bus.BUSY  = w_valid;
    assign bus.OVR   = r_ovr;

endmodule

// File: tb/tb_capture_shift_1.sv
// -----------------------------------------------------------------------------
// tb_capture_shift_1
//   Directed bench for capture_shift_1 (WIDTH=16, INIT=1). Inputs change
//   1 time unit after each falling edge and outputs are sampled there too,
//   half a period away from the next active edge. Expected values follow
//   the CAPTURE_PARITY_EN setting of the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_capture_shift_1;

    localparam int WIDTH = 16;
`ifdef CAPTURE_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic C      = 1'b1;
    logic CLR    = 1'b0;
    bit   clk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    capture_shift_1_if #(.WIDTH(WIDTH)) bus ();

    capture_shift_1 #(
        .WIDTH (WIDTH),
        .INIT  (1'b1)
    ) u_dut (
        .C   (C),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 if (clk_en) C = ~C;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected serial bit k of a frame carrying word w (MSB first, then parity).
    function automatic logic exp_bit(input logic [15:0] w, input int k);
        if (k < WIDTH) return w[WIDTH-1-k];
        return ^w;
    endfunction

    task automatic step();
        @(negedge C);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic [15:0] w, input int k);
        check($sformatf("%s_q%0d", tag, k),     {31'd0, bus.Q},     {31'd0, exp_bit(w, k)});
        check($sformatf("%s_valid%0d", tag, k), {31'd0, bus.VALID}, 32'd1);
        check($sformatf("%s_last%0d", tag, k),  {31'd0, bus.LAST},  {31'd0, (k == FRAME-1)});
        check($sformatf("%s_busy%0d", tag, k),  {31'd0, bus.BUSY},  32'd1);
    endtask

    task automatic check_idle(input string tag, input logic exp_ovr);
        check({tag, "_q"},     {31'd0, bus.Q},     32'd1);
        check({tag, "_valid"}, {31'd0, bus.VALID}, 32'd0);
        check({tag, "_last"},  {31'd0, bus.LAST},  32'd0);
        check({tag, "_busy"},  {31'd0, bus.BUSY},  32'd0);
        check({tag, "_ovr"},   {31'd0, bus.OVR},   {31'd0, exp_ovr});
    endtask

    // Accept bits from..to with RDY high, checking each before its edge.
    task automatic run_bits(input string tag, input logic [15:0] w, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            check_bit(tag, w, k);
            step();
        end
    endtask

    // Capture w on the next edge; D is then scrambled to show it is not re-read.
    task automatic start(input logic [15:0] w);
        bus.D   = w;
        bus.CAP = 1'b1;
        step();
        bus.CAP = 1'b0;
        bus.D   = ~w;
    endtask

    initial begin
        bus.CE  = 1'b0;
        bus.CAP = 1'b0;
        bus.D   = '0;
        bus.RDY = 1'b1;

        // Reset with no clock running.
        #1 CLR = 1'b1;
        #1 check_idle("reset", 1'b0);
        CLR     = 1'b0;
        bus.CE  = 1'b1;
        clk_en  = 1'b1;

        // Basic frame.
        start(16'hA5C3);
        run_bits("basic", 16'hA5C3, 0, FRAME-1);
        check_idle("basic_end", 1'b0);

        // Stall: RDY low for 3 edges, then CE low for 2 edges with CAP high.
        start(16'hA5C3);
        run_bits("stall", 16'hA5C3, 0, 3);
        check_bit("stall_pre", 16'hA5C3, 4);
        bus.RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bit($sformatf("stall_rdy%0d", i), 16'hA5C3, 4);
        end
        bus.RDY = 1'b1;
        bus.CE  = 1'b0;
        bus.CAP = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_bit($sformatf("stall_ce%0d", i), 16'hA5C3, 4);
            check($sformatf("stall_ce%0d_ovr", i), {31'd0, bus.OVR}, 32'd0);
        end
        bus.CE  = 1'b1;
        bus.CAP = 1'b0;
        run_bits("stall", 16'hA5C3, 4, FRAME-1);
        check_idle("stall_end", 1'b0);

        // Dropped request at bit 7.
        start(16'hA5C3);
        run_bits("drop", 16'hA5C3, 0, 6);
        check_bit("drop_pre", 16'hA5C3, 7);
        bus.D   = 16'hFFFF;
        bus.CAP = 1'b1;
        step();
        bus.CAP = 1'b0;
        check("drop_ovr_set", {31'd0, bus.OVR}, 32'd1);
        run_bits("drop", 16'hA5C3, 8, FRAME-1);
        check_idle("drop_end", 1'b1);
        CLR = 1'b1;
        #1 check_idle("drop_clr", 1'b0);
        CLR = 1'b0;

        // Back-to-back: new capture on the final-bit acceptance edge.
        start(16'hA5C3);
        run_bits("b2b_a", 16'hA5C3, 0, FRAME-2);
        check_bit("b2b_a", 16'hA5C3, FRAME-1);
        bus.D   = 16'h0001;
        bus.CAP = 1'b1;
        step();
        bus.CAP = 1'b0;
        bus.D   = 16'hFFFE;
        check("b2b_ovr", {31'd0, bus.OVR}, 32'd0);
        run_bits("b2b_b", 16'h0001, 0, FRAME-1);
        check_idle("b2b_end", 1'b0);

        // Abort at bit 9, then a clean restart.
        start(16'hA5C3);
        run_bits("abort", 16'hA5C3, 0, 8);
        check_bit("abort_pre", 16'hA5C3, 9);
        CLR = 1'b1;
        #1 check_idle("abort_clr", 1'b0);
        CLR = 1'b0;
        @(negedge C);
        #1 check_idle("abort_idle", 1'b0);
        start(16'hA5C3);
        run_bits("restart", 16'hA5C3, 0, FRAME-1);
        check_idle("restart_end", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capture_shift_1.md
# capture_shift_1

Falling-edge-clocked capture and serial readback register. It snapshots a parallel word from a bank of inverted-clock flip-flops and streams it out MSB-first over a valid/ready serial handshake. It is the read side of the flip-flop bank: the flops store state, and this block captures and returns that state to a readback or debug controller. It runs on the same inverted clock domain as the flops it samples.

## Interface
Parameters:
- WIDTH, 16, captured word width in bits; legal range 2..64.
- INIT, 1'b0, value driven on Q whenever no frame is active.

Ports:
- C, input, 1, clock; all state changes on the falling edge.
- CLR, input, 1, reset CLR, asynchronous, active-high.
- CE, input, 1, clock enable; when low, every synchronous update is suppressed.
- CAP, input, 1, capture request; sampled on the falling edge of C.
- D, input, WIDTH, parallel word to capture.
- RDY, input, 1, consumer ready for the current serial bit.
- Q, output, 1, current serial bit.
- VALID, output, 1, Q holds a bit of an active frame.
- LAST, output, 1, Q holds the final bit of the frame.
- BUSY, output, 1, a frame is in progress (equal to VALID).
- OVR, output, 1, sticky flag: a capture request was dropped.

## Operation
- States:
  - IDLE: no frame.
  - SHIFT: frame active.
- Internal registers:
  - shadow register, WIDTH bits.
  - bit counter, clog2(WIDTH+2) bits.
- CLR high, asynchronous and dominant over everything else:
  - state returns to IDLE.
  - shadow and counter clear to 0.
  - Q=INIT, VALID=0, LAST=0, BUSY=0, OVR=0.
- Frame start. In IDLE, a falling edge with CE=1 and CAP=1:
  - shadow<=D and counter<=0.
  - state moves to SHIFT, VALID=1.
  - Q=D[WIDTH-1].
- Transfer. A bit is accepted on a falling edge where CE=1, VALID=1 and RDY=1.
  - On acceptance, shadow shifts left by one and the counter increments.
  - Q always shows the MSB of shadow, or the trailer bit when one is configured.
- LAST is high while the counter equals FRAME-1, where FRAME=WIDTH, or WIDTH+1 with parity.
- Frame end. Acceptance while LAST=1:
  - state returns to IDLE.
  - VALID=0, LAST=0, Q=INIT.
- Back-to-back frames. If CAP=1 on the same edge that accepts the last bit:
  - the new capture loads immediately and VALID stays 1 with no gap.
  - OVR is not set.
- Dropped request. CAP=1 with CE=1 in SHIFT, when that edge is not a final-bit acceptance:
  - the request is ignored.
  - OVR<=1; only CLR clears OVR.
- While VALID=1 and RDY=0, Q, LAST and the counter hold. This is the stall case.
- D is sampled only at frame start. Changes to D during SHIFT have no effect.

## Timing
- Capture latency: Q/VALID valid immediately after the falling edge that samples CAP, i.e. 1 edge.
- Throughput: one bit per falling edge when RDY is held high. A WIDTH-bit frame takes WIDTH edges.
- Outputs are registered and there are no combinational paths from input to output.
- CLR assertion takes effect with no clock.
- The first falling edge after CLR deasserts is fully functional.
- CLR asserted mid-frame aborts the frame. No partial-frame indication remains.

## Configuration
- CAPTURE_PARITY_EN defined:
  - FRAME=WIDTH+1.
  - After the data bits, one trailer bit is sent: the even parity (XOR) of the captured word.
  - The parity is computed at capture time and held while the frame is active.
  - LAST marks the parity bit.
- Undefined: FRAME=WIDTH, and LAST marks data bit 0.

## Test plan
- Reset: CLR=1 with INIT=1 and no clock -> Q=1, VALID=0, LAST=0, BUSY=0, OVR=0.
- Basic frame: WIDTH=16, D=16'hA5C3, CAP pulse, RDY=1.
  - Q over 16 edges = 1010_0101_1100_0011.
  - LAST on the 16th bit, then VALID=0 and Q=INIT.
  - With CAPTURE_PARITY_EN, the 17th bit is 0.
- Stall: RDY=0 for 3 edges after bit 4 -> Q, LAST and the counter hold; the full frame is still correct. CE=0 for 2 edges -> no change in any output.
- Dropped request: CAP pulse at bit 7 with D=16'hFFFF -> the frame continues with 16'hA5C3 and OVR=1 until CLR.
- Back-to-back: CAP=1 with D=16'h0001 on the final-bit acceptance edge -> VALID stays 1, the next bit is 0 (MSB of 16'h0001), and OVR=0.
- Abort: CLR pulse at bit 9 -> immediate idle outputs. A new CAP then restarts a clean frame from bit 15.
